// File: rtl/rtc_alrm_sched.sv
// Multi-slot alarm scheduler: sole APB4 master of the RTC, brings it up after reset
// and keeps the ALRM register loaded with the earliest armed slot.
module rtc_alrm_sched #(
    parameter int          NUM_SLOT   = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [31:0] PSCR_VAL   = 32'd2,
    parameter int          SETTLE_CYC = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    output logic [31:0]                 paddr_o,
    output logic                        psel_o,
    output logic                        penable_o,
    output logic                        pwrite_o,
    output logic [31:0]                 pwdata_o,
    output logic [3:0]                  pstrb_o,
    output logic [2:0]                  pprot_o,
    input  logic [31:0]                 prdata_i,
    input  logic                        pready_i,
    input  logic                        pslverr_i,
    input  logic                        irq_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_cancel_i,
    input  logic [$clog2(NUM_SLOT)-1:0] req_slot_i,
    input  logic [31:0]                 req_time_i,
    output logic                        fire_o,
    output logic [$clog2(NUM_SLOT)-1:0] fire_slot_o,
    output logic                        busy_o,
    output logic                        err_o
);

    // state     | meaning
    // INIT_CMF  | write CTRL=0x01 (clear compare match)
    // INIT_POLL | read SSTA until LWOFF
    // INIT_PSCR | write PSCR
    // INIT_EN   | write CTRL=0x10 (enable counter)
    // IDLE      | accept irq or arm/cancel request
    // PROG      | write CTRL=0x11, or go straight to WR_CTRL if nothing armed
    // SVC_CTRL  | write CTRL=0x11 (ALRMIE off)
    // RD_ISTA   | read ISTA (clears it)
    // RD_CNT    | read CNT into cnt_q
    // FIRE      | fire one expired slot per cycle
    // POLL      | read SSTA until LWOFF
    // WR_ALRM   | write ALRM = earliest slot time
    // SETTLE    | down-count SETTLE_CYC cycles
    // WR_CTRL   | write CTRL=0x14 (ie_q) or 0x10

    localparam int SW = $clog2(NUM_SLOT);

    localparam logic [31:0] OFF_CTRL = 32'h00;
    localparam logic [31:0] OFF_PSCR = 32'h04;
    localparam logic [31:0] OFF_CNT  = 32'h08;
    localparam logic [31:0] OFF_ALRM = 32'h0C;
    localparam logic [31:0] OFF_ISTA = 32'h10;
    localparam logic [31:0] OFF_SSTA = 32'h14;

    typedef enum logic [3:0] {
        S_INIT_CMF, S_INIT_POLL, S_INIT_PSCR, S_INIT_EN, S_IDLE, S_PROG, S_SVC_CTRL,
        S_RD_ISTA, S_RD_CNT, S_FIRE, S_POLL, S_WR_ALRM, S_SETTLE, S_WR_CTRL
    } state_t;

    state_t               state_q, state_d;
    logic                 psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [31:0]          paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic                 ie_q, ie_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [7:0]           settle_q, settle_d;
    logic                 fire_q, fire_d;
    logic [SW-1:0]        fire_slot_q, fire_slot_d;
    logic                 err_q, err_d;
    logic [NUM_SLOT-1:0]  valid_q, valid_d;
    logic [31:0]          slot_tm_q [NUM_SLOT];
    logic [31:0]          slot_tm_d [NUM_SLOT];

    logic                 any_valid, hit, done;
    logic [31:0]          earliest;
    logic [SW-1:0]        hit_idx;
    logic                 xfer_en, xfer_wr;
    logic [31:0]          xfer_off, xfer_data;

    assign done = psel_q & penable_q & pready_i;

    // earliest armed slot (ties -> lowest index) and lowest expired slot
    always_comb begin
        any_valid = 1'b0;
        earliest  = '0;
        hit       = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < NUM_SLOT; i++) begin
            if (valid_q[i] && (!any_valid || slot_tm_q[i] < earliest)) begin
                earliest = slot_tm_q[i];
            end
            if (valid_q[i]) begin
                any_valid = 1'b1;
            end
            if (valid_q[i] && !hit && slot_tm_q[i] <= cnt_q) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        ie_d        = ie_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        fire_d      = 1'b0;
        fire_slot_d = fire_slot_q;
        err_d       = err_q | (done & pslverr_i);
        valid_d     = valid_q;
        slot_tm_d   = slot_tm_q;
        xfer_en     = 1'b0;
        xfer_wr     = 1'b1;
        xfer_off    = OFF_CTRL;
        xfer_data   = '0;

        case (state_q)
            S_INIT_CMF: begin
                xfer_en = 1'b1; xfer_data = 32'h01;
                if (done) state_d = S_INIT_POLL;
            end
            S_INIT_POLL: begin
                xfer_en = 1'b1; xfer_wr = 1'b0; xfer_off = OFF_SSTA;
                if (done && prdata_i[1]) state_d = S_INIT_PSCR;
            end
            S_INIT_PSCR: begin
                xfer_en = 1'b1; xfer_off = OFF_PSCR; xfer_data = PSCR_VAL;
                if (done) state_d = S_INIT_EN;
            end
            S_INIT_EN: begin
                xfer_en = 1'b1; xfer_data = 32'h10;
                if (done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (irq_i) begin
                    state_d = S_SVC_CTRL;
                end else if (req_valid_i) begin
                    for (int i = 0; i < NUM_SLOT; i++) begin
                        if (req_slot_i == SW'(i)) begin
                            valid_d[i] = ~req_cancel_i;
                            if (!req_cancel_i) slot_tm_d[i] = req_time_i;
                        end
                    end
                    state_d = S_PROG;
                end
            end
            S_PROG: begin
                if (!any_valid) begin
                    ie_d    = 1'b0;
                    state_d = S_WR_CTRL;
                end else begin
                    xfer_en = 1'b1; xfer_data = 32'h11;
                    if (done) state_d = S_POLL;
                end
            end
            S_SVC_CTRL: begin
                xfer_en = 1'b1; xfer_data = 32'h11;
                if (done) state_d = S_RD_ISTA;
            end
            S_RD_ISTA: begin
                xfer_en = 1'b1; xfer_wr = 1'b0; xfer_off = OFF_ISTA;
                if (done) state_d = S_RD_CNT;
            end
            S_RD_CNT: begin
                xfer_en = 1'b1; xfer_wr = 1'b0; xfer_off = OFF_CNT;
                if (done) begin
                    cnt_d   = prdata_i;
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                if (hit) begin
                    fire_d           = 1'b1;
                    fire_slot_d      = hit_idx;
                    valid_d[hit_idx] = 1'b0;
                end else if (any_valid) begin
                    state_d = S_POLL;
                end else begin
                    ie_d    = 1'b0;
                    state_d = S_WR_CTRL;
                end
            end
            S_POLL: begin
                xfer_en = 1'b1; xfer_wr = 1'b0; xfer_off = OFF_SSTA;
                if (done && prdata_i[1]) state_d = S_WR_ALRM;
            end
            S_WR_ALRM: begin
                xfer_en = 1'b1; xfer_off = OFF_ALRM; xfer_data = earliest;
                if (done) begin
                    settle_d = 8'(SETTLE_CYC - 1);
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == 8'd0) begin
                    ie_d    = 1'b1;
                    state_d = S_WR_CTRL;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            S_WR_CTRL: begin
                xfer_en = 1'b1; xfer_data = ie_q ? 32'h14 : 32'h10;
                if (done) state_d = S_IDLE;
            end
            default: state_d = S_INIT_CMF;
        endcase

        // one transfer at a time: SETUP, ACCESS until pready, then one idle bus cycle
        if (xfer_en) begin
            if (!psel_q) begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                pwrite_d  = xfer_wr;
                paddr_d   = BASE_ADDR + xfer_off;
                pwdata_d  = xfer_wr ? xfer_data : 32'h0;
            end else if (!penable_q) begin
                penable_d = 1'b1;
            end else if (pready_i) begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_INIT_CMF;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            ie_q        <= 1'b0;
            cnt_q       <= '0;
            settle_q    <= '0;
            fire_q      <= 1'b0;
            fire_slot_q <= '0;
            err_q       <= 1'b0;
            valid_q     <= '0;
            for (int i = 0; i < NUM_SLOT; i++) slot_tm_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            ie_q        <= ie_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            fire_q      <= fire_d;
            fire_slot_q <= fire_slot_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            slot_tm_q   <= slot_tm_d;
        end
    end

    assign paddr_o     = paddr_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = 4'hF;
    assign pprot_o     = 3'b000;
    assign req_ready_o = (state_q == S_IDLE) & ~irq_i;
    assign busy_o      = (state_q != S_IDLE);
    assign fire_o      = fire_q;
    assign fire_slot_o = fire_slot_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rtc_alrm_sched.sv
// Bench for rtc_alrm_sched: behavioural RTC slave plus a slot-list model that predicts
// the APB transfer log and the fire sequence for every arm/cancel/irq operation.
module tb_rtc_alrm_sched;

    localparam int NS = 4;
    localparam int SW = 2;

    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_PSCR = 32'h04;
    localparam logic [31:0] A_CNT  = 32'h08;
    localparam logic [31:0] A_ALRM = 32'h0C;
    localparam logic [31:0] A_ISTA = 32'h10;
    localparam logic [31:0] A_SSTA = 32'h14;

    typedef struct packed {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   paddr, pwdata, prdata = '0;
    logic          psel, penable, pwrite;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          pready = 1'b0, pslverr = 1'b0;
    logic          irq;
    logic          req_valid, req_ready, req_cancel;
    logic [SW-1:0] req_slot;
    logic [31:0]   req_tm;
    logic          fire;
    logic [SW-1:0] fire_slot;
    logic          busy, err;

    always #5 clk = ~clk;

    rtc_alrm_sched #(.NUM_SLOT(NS), .BASE_ADDR(32'h0), .PSCR_VAL(32'd2), .SETTLE_CYC(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
        .irq_i(irq),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cancel_i(req_cancel),
        .req_slot_i(req_slot), .req_time_i(req_tm),
        .fire_o(fire), .fire_slot_o(fire_slot), .busy_o(busy), .err_o(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          irq_req_cnt = 0;
    int          ista_rd_cnt = 0;
    int          wait_cfg = 0;
    bit          rand_wait = 1'b0;
    int          ssta_zero_cfg = 0;
    int          ssta_zcnt = 0;
    int          err_at = -1;
    int          xfer_total = 0;
    int          proto_err = 0;
    logic [31:0] cnt_val = '0;
    xfer_t       obs_q[$];
    int          fire_obs[$];

    logic [31:0] s_addr, s_data;
    logic        s_wr;
    bit          in_xfer = 1'b0;
    int          rem = 0;

    assign irq = (irq_req_cnt != ista_rd_cnt);

    // RTC slave: reacts on the falling edge, logs each transfer when it completes
    always @(negedge clk) begin
        if (!rst_n) begin
            pready = 1'b0; pslverr = 1'b0; prdata = '0;
            in_xfer = 1'b0; rem = 0; ssta_zcnt = 0;
        end else if (psel && !penable) begin
            if (in_xfer) proto_err++;
            in_xfer = 1'b1;
            s_addr = paddr; s_wr = pwrite; s_data = pwdata;
            rem = rand_wait ? int'($urandom_range(3, 0)) : wait_cfg;
            pready = 1'b0; pslverr = 1'b0;
        end else if (psel && penable) begin
            if (!in_xfer || paddr !== s_addr || pwrite !== s_wr || pwdata !== s_data ||
                pstrb !== 4'hF || pprot !== 3'b000) proto_err++;
            if (rem > 0) begin
                rem--;
                pready = 1'b0;
            end else begin
                xfer_t x;
                pready  = 1'b1;
                pslverr = (xfer_total == err_at);
                prdata  = '0;
                if (!s_wr) begin
                    case (s_addr)
                        A_SSTA: begin
                            if (ssta_zcnt < ssta_zero_cfg) begin
                                ssta_zcnt++;
                            end else begin
                                ssta_zcnt = 0;
                                prdata = 32'h2;
                            end
                        end
                        A_CNT:  prdata = cnt_val;
                        A_ISTA: begin prdata = 32'h1; ista_rd_cnt++; end
                        default: prdata = '0;
                    endcase
                end
                x.a = s_addr; x.w = s_wr; x.d = s_data;
                obs_q.push_back(x);
                xfer_total++;
                in_xfer = 1'b0;
            end
        end else begin
            if (in_xfer) begin
                proto_err++;
                in_xfer = 1'b0;
            end
            pready = 1'b0; pslverr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && fire) fire_obs.push_back(int'(fire_slot));
    end

    bit          m_valid [NS];
    logic [31:0] m_time  [NS];
    xfer_t       exp_q[$];
    int          exp_fire[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void exp_push(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t x;
        x.a = a; x.w = w; x.d = d;
        exp_q.push_back(x);
    endfunction

    function automatic bit m_any();
        bit any = 1'b0;
        for (int i = 0; i < NS; i++) any |= m_valid[i];
        return any;
    endfunction

    // reprogram after the slot list changed: poll, ALRM=min time, re-enable; or just disable
    function automatic void exp_tail();
        logic [31:0] best = '1;
        for (int i = 0; i < NS; i++) if (m_valid[i] && m_time[i] < best) best = m_time[i];
        for (int i = 0; i < NS; i++) if (m_valid[i] && m_time[i] == best) break;
        if (m_any()) begin
            for (int k = 0; k <= ssta_zero_cfg; k++) exp_push(A_SSTA, 1'b0, '0);
            exp_push(A_ALRM, 1'b1, best);
            exp_push(A_CTRL, 1'b1, 32'h14);
        end else begin
            exp_push(A_CTRL, 1'b1, 32'h10);
        end
    endfunction

    function automatic void model_req(input bit cancel, input int slot, input logic [31:0] t);
        m_valid[slot] = !cancel;
        if (!cancel) m_time[slot] = t;
        if (m_any()) exp_push(A_CTRL, 1'b1, 32'h11);
        exp_tail();
    endfunction

    function automatic void model_irq(input logic [31:0] c);
        exp_push(A_CTRL, 1'b1, 32'h11);
        exp_push(A_ISTA, 1'b0, '0);
        exp_push(A_CNT,  1'b0, '0);
        for (int i = 0; i < NS; i++) begin
            if (m_valid[i] && m_time[i] <= c) begin
                exp_fire.push_back(i);
                m_valid[i] = 1'b0;
            end
        end
        exp_tail();
    endfunction

    function automatic void model_init();
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        exp_push(A_CTRL, 1'b1, 32'h01);
        for (int k = 0; k <= ssta_zero_cfg; k++) exp_push(A_SSTA, 1'b0, '0);
        exp_push(A_PSCR, 1'b1, 32'h02);
        exp_push(A_CTRL, 1'b1, 32'h10);
    endfunction

    task automatic compare_logs(input string ph);
        chk({ph, ":n_xfer"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({ph, ":xfer_addr"}, obs_q[i].a, exp_q[i].a);
            chk({ph, ":xfer_wr"}, 32'(obs_q[i].w), 32'(exp_q[i].w));
            if (exp_q[i].w) chk({ph, ":xfer_data"}, obs_q[i].d, exp_q[i].d);
        end
        chk({ph, ":n_fire"}, fire_obs.size(), exp_fire.size());
        for (int i = 0; i < fire_obs.size() && i < exp_fire.size(); i++)
            chk({ph, ":fire_slot"}, fire_obs[i], exp_fire[i]);
        chk({ph, ":apb_proto"}, proto_err, 0);
        obs_q.delete(); exp_q.delete(); fire_obs.delete(); exp_fire.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        chk({tag, ":idle"}, 32'(busy), 0);
    endtask

    task automatic do_req(input bit cancel, input int slot, input logic [31:0] t);
        int n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_pre", 32'(req_ready), 1);
        req_valid = 1'b1; req_cancel = cancel; req_slot = SW'(slot); req_tm = t;
        @(posedge clk);
        #1 req_valid = 1'b0;
        model_req(cancel, slot, t);
        wait_idle("req");
        compare_logs("req");
    endtask

    task automatic do_irq(input logic [31:0] c);
        cnt_val = c;
        irq_req_cnt++;
        model_irq(c);
        wait_idle("irq");
        compare_logs("irq");
    endtask

    task automatic chk_reset_outputs(input string ph);
        chk({ph, ":psel"}, 32'(psel), 0);
        chk({ph, ":penable"}, 32'(penable), 0);
        chk({ph, ":pwrite"}, 32'(pwrite), 0);
        chk({ph, ":paddr"}, paddr, 0);
        chk({ph, ":pwdata"}, pwdata, 0);
        chk({ph, ":fire"}, 32'(fire), 0);
        chk({ph, ":fire_slot"}, 32'(fire_slot), 0);
        chk({ph, ":err"}, 32'(err), 0);
        chk({ph, ":req_ready"}, 32'(req_ready), 0);
        chk({ph, ":busy"}, 32'(busy), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_cancel = 1'b0; req_slot = '0; req_tm = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // bring-up with a zero-wait slave
        rst_n = 1'b1;
        model_init();
        @(posedge clk);
        #1 chk("first_setup", {psel, penable}, 2'b10);
        wait_idle("init");
        compare_logs("init");
        chk("init_req_ready", 32'(req_ready), 1);

        do_req(1'b0, 2, 32'h100);
        chk("req_ready_back", 32'(req_ready), 1);
        do_req(1'b1, 2, 32'h0);

        do_req(1'b0, 0, 32'h100);
        do_req(1'b0, 3, 32'h105);
        do_req(1'b0, 1, 32'h200);
        do_irq(32'h105);

        // backpressure, SSTA polled repeatedly, one slave error
        chk("err_before", 32'(err), 0);
        wait_cfg = 5; ssta_zero_cfg = 3; err_at = xfer_total + 2;
        do_req(1'b0, 0, 32'h150);
        chk("err_set", 32'(err), 1);
        err_at = -1;
        do_irq(32'h150);
        chk("err_sticky", 32'(err), 1);

        // irq and request in the same IDLE cycle: irq first
        wait_cfg = 0; ssta_zero_cfg = 0;
        cnt_val = 32'h200;
        irq_req_cnt++;
        req_valid = 1'b1; req_cancel = 1'b0; req_slot = 2'd2; req_tm = 32'h300;
        #1 chk("irq_wins", 32'(req_ready), 0);
        model_irq(32'h200);
        model_req(1'b0, 2, 32'h300);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 2000);
        chk("late_accept", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_idle("both");
        compare_logs("both");

        // randomized mix of arm, cancel and irq under random wait states
        rand_wait = 1'b1;
        for (int k = 0; k < 30; k++) begin
            int op = int'($urandom_range(3, 0));
            ssta_zero_cfg = int'($urandom_range(2, 0));
            if (op <= 1)
                do_req(1'b0, int'($urandom_range(NS - 1, 0)), 32'h100 + $urandom_range(63, 0));
            else if (op == 2)
                do_req(1'b1, int'($urandom_range(NS - 1, 0)), 32'h0);
            else
                do_irq(32'h100 + $urandom_range(80, 0));
        end

        // reset during the ACCESS phase of the CNT read
        rand_wait = 1'b0; wait_cfg = 5; ssta_zero_cfg = 0;
        cnt_val = 32'h400;
        irq_req_cnt++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(psel && penable && paddr == A_CNT) && n < 500);
        chk("reach_rd_cnt", {psel, penable}, 2'b11);
        rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        obs_q.delete(); fire_obs.delete(); exp_q.delete(); exp_fire.delete();
        repeat (2) @(negedge clk);
        wait_cfg = 0;
        model_init();
        rst_n = 1'b1;
        wait_idle("reinit");
        compare_logs("reinit");

        // slots must have been wiped: only the new arm may fire
        do_req(1'b0, 1, 32'h123);
        do_irq(32'h500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
